pdpu_dot_seq: RTL

Sequencer directly upstream and around the combinational pdpu_top. It accepts a stream of N-element operand chunks over a valid/ready handshake. It registers each chunk and drives it, together with a running accumulator, into pdpu_top, then feeds the result back as the next acc. The result is emitted on an output handshake after the last chunk of a chain, so dot products of arbitrary length run at one chunk per cycle.

---
 rtl/pdpu_pkg.sv | 12 +
 rtl/pdpu_dot_seq_if.sv | 39 +++
 rtl/pdpu_dot_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/pdpu_pkg.sv
// Shared types and constants for the posit dot-product sequencer.
package pdpu_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } chain_state_e;

  // Bit pattern of posit zero at any width; size-cast at the point of use.
  localparam int unsigned POSIT_ZERO = '0;

endpackage

// File: rtl/pdpu_dot_seq_if.sv
// Chunk input stream, result output stream and the link to the combinational
// pdpu_top, bundled for the dot-product sequencer.
interface pdpu_dot_seq_if #(
  parameter int N         = 4,
  parameter int n_i       = 8,
  parameter int n_o       = 16,
  parameter int CNT_WIDTH = 16
);
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [N*n_i-1:0]     in_a_i;
  logic [N*n_i-1:0]     in_b_i;
  logic                 in_first_i;
  logic                 in_last_i;
  logic [n_o-1:0]       init_acc_i;
  logic [N*n_i-1:0]     pdpu_a_o;
  logic [N*n_i-1:0]     pdpu_b_o;
  logic [n_o-1:0]       pdpu_acc_o;
  logic [n_o-1:0]       pdpu_result_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [n_o-1:0]       out_data_o;
  logic [CNT_WIDTH-1:0] out_beats_o;
  logic                 err_o;

  modport slave (
    input  in_valid_i, in_a_i, in_b_i, in_first_i, in_last_i, init_acc_i,
           pdpu_result_i, out_ready_i,
    output in_ready_o, pdpu_a_o, pdpu_b_o, pdpu_acc_o, out_valid_o,
           out_data_o, out_beats_o, err_o
  );

  modport master (
    output in_valid_i, in_a_i, in_b_i, in_first_i, in_last_i, init_acc_i,
           pdpu_result_i, out_ready_i,
    input  in_ready_o, pdpu_a_o, pdpu_b_o, pdpu_acc_o, out_valid_o,
           out_data_o, out_beats_o, err_o
  );
endinterface

// File: rtl/pdpu_dot_seq.sv
// Streams operand chunks through the combinational pdpu_top, feeding each
// result back as the next accumulator and emitting one result per chain.
module pdpu_dot_seq
  import pdpu_pkg::*;
#(
  parameter int N         = 4,
  parameter int n_i       = 8,
  parameter int n_o       = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pdpu_dot_seq_if.slave    bus
);

  // state | meaning
  // IDLE  | no chain open; the next accepted chunk starts one
  // ACCUM | chain open; accumulating until its last chunk is accepted

  chain_state_e         state_q, state_d;
  logic                 op_valid_q, op_last_q;
  logic [N*n_i-1:0]     op_a_q, op_b_q;
  logic [n_o-1:0]       acc_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 out_valid_q;
  logic [n_o-1:0]       out_data_q;
  logic [CNT_WIDTH-1:0] out_beats_q;
  logic                 err_q, err_d;
  logic                 adv, accept, retire, start;

  // The stage only stalls when it holds a last beat that has nowhere to go.
  assign adv    = !op_valid_q || !op_last_q || !out_valid_q || bus.out_ready_i;
  assign accept = bus.in_valid_i && adv;
  assign retire = op_valid_q && adv;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    err_d   = 1'b0;
    if (accept) begin
      // A stray non-first chunk in IDLE opens a chain of its own.
      start   = bus.in_first_i || (state_q == IDLE);
      err_d   = bus.in_first_i == (state_q == ACCUM);
      state_d = bus.in_last_i ? IDLE : ACCUM;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_valid_q  <= 1'b0;
      op_last_q   <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      acc_q       <= n_o'(POSIT_ZERO);
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= n_o'(POSIT_ZERO);
      out_beats_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (adv) begin
        op_valid_q <= bus.in_valid_i;
        op_last_q  <= bus.in_last_i;
        op_a_q     <= bus.in_a_i;
        op_b_q     <= bus.in_b_i;
      end

      if (accept && start) begin
        acc_q <= bus.init_acc_i;
      end else if (retire && !op_last_q) begin
        acc_q <= bus.pdpu_result_i;
      end

      if (accept) begin
        if (start) begin
          cnt_q <= CNT_WIDTH'(1);
        end else if (cnt_q != '1) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      if (retire && op_last_q) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.pdpu_result_i;
        out_beats_q <= cnt_q;
      end else if (bus.out_ready_i) begin
        out_valid_q <= 1'b0;
      end

      err_q <= err_d;
    end
  end

  assign bus.in_ready_o  = adv;
  assign bus.pdpu_a_o    = op_a_q;
  assign bus.pdpu_b_o    = op_b_q;
  assign bus.pdpu_acc_o  = acc_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_beats_o = out_beats_q;
  assign bus.err_o       = err_q;

endmodule
